// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e : fetch sequencer states (BOOT bubble, RUN, TRAP)
//   ILEN16/ILEN32 : PC step, in bytes, for compressed and full-width instructions
//   is_compressed : classifies an instruction from its two low opcode bits
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_e;

    localparam int ILEN16 = 2;
    localparam int ILEN32 = 4;

    // RVC encodings use every low-bit pattern except 2'b11.
    function automatic logic is_compressed(input logic [1:0] opcode_low);
        return opcode_low != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection for the fetch controller.
// Priority: redirect, then sequential advance (+2 or +4), else hold.
// Ports:
//   pc             in  WIDTH  current program counter
//   redirect_valid in  1      redirect requested this cycle
//   redirect_pc    in  WIDTH  redirect target
//   advance        in  1      a non-fault instruction is being loaded
//   compressed     in  1      the loaded instruction is 16-bit
//   pc_next        out WIDTH  value for the PC register at the next edge
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             advance,
    input  logic             compressed,
    output logic [WIDTH-1:0] pc_next
);

    localparam logic [WIDTH-1:0] STEP16 = WIDTH'(ILEN16);
    localparam logic [WIDTH-1:0] STEP32 = WIDTH'(ILEN32);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (advance) begin
            // Wraps modulo 2^WIDTH by construction.
            pc_next = pc + (compressed ? STEP16 : STEP32);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller in front of a combinational IMEM.
// Owns the PC, classifies each fetched window as RVC or 32-bit, and hands
// one instruction (or fetch fault) per valid/ready handshake to decode.
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   imem_addr        out  byte address to IMEM (the PC register)
//   imem_instr       in   32-bit window at imem_addr
//   imem_misalign    in   odd-address flag from IMEM
//   redirect_valid   in   branch/jump/trap redirect this cycle
//   redirect_pc      in   redirect target
//   if_valid/if_ready     handshake toward decode
//   if_instr         out  instruction (upper half zero for RVC, zero on fault)
//   if_pc            out  PC of if_instr
//   if_compressed    out  if_instr is 16-bit
//   if_fault         out  misaligned or out-of-range fetch
//   fetch_count      out  accepted non-fault instructions, wrapping
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               IMEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             imem_misalign,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic             if_compressed,
    output logic             if_fault,
    output logic [31:0]      fetch_count
);

    fetch_state_e     state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             if_valid_reg, if_valid_next;
    logic [WIDTH-1:0] if_instr_reg, if_instr_next;
    logic [WIDTH-1:0] if_pc_reg, if_pc_next;
    logic             if_compressed_reg, if_compressed_next;
    logic             if_fault_reg, if_fault_next;
    logic [31:0]      fetch_count_reg, fetch_count_next;

    logic             fetch_compressed;
    logic             fetch_out_of_range;
    logic             fetch_fault;
    logic             load;
    logic             handshake;

    // One extra bit so the range compare cannot wrap near the top of memory.
    logic [WIDTH:0]   pc_ext;
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(IMEM_BYTES);

    assign imem_addr        = pc_reg;
    assign fetch_compressed = is_compressed(imem_instr[1:0]);
    assign pc_ext           = {1'b0, pc_reg};

    // A 32-bit fetch needs its upper halfword inside memory as well.
    assign fetch_out_of_range = fetch_compressed ? (pc_ext >= LIMIT)
                                                 : (pc_ext + (WIDTH+1)'(2) >= LIMIT);
    assign fetch_fault = imem_misalign || fetch_out_of_range;

    assign handshake = if_valid_reg && if_ready;
    assign load      = (state_reg == RUN) && (!if_valid_reg || if_ready);

    fetch_pc_next #(
        .WIDTH (WIDTH)
    ) u_pc_next (
        .pc             (pc_reg),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (load && !fetch_fault),
        .compressed     (fetch_compressed),
        .pc_next        (pc_next)
    );

    always_comb begin
        state_next         = state_reg;
        if_valid_next      = if_valid_reg;
        if_instr_next      = if_instr_reg;
        if_pc_next         = if_pc_reg;
        if_compressed_next = if_compressed_reg;
        if_fault_next      = if_fault_reg;
        // A handshake counts even when a redirect flushes in the same cycle.
        fetch_count_next   = fetch_count_reg
                           + ((handshake && !if_fault_reg) ? 32'd1 : 32'd0);

        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (load) begin
                    if_valid_next = 1'b1;
                    if_pc_next    = pc_reg;
                    if (fetch_fault) begin
                        if_fault_next      = 1'b1;
                        if_instr_next      = '0;
                        if_compressed_next = 1'b0;
                        state_next         = TRAP;
                    end else begin
                        if_fault_next      = 1'b0;
                        if_compressed_next = fetch_compressed;
                        if_instr_next      = fetch_compressed
                                           ? {{(WIDTH-16){1'b0}}, imem_instr[15:0]}
                                           : imem_instr;
                    end
                end
            end
            TRAP: begin
                // Fault remains presented until decode takes it; then idle.
                if (handshake) begin
                    if_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        // Redirect flushes whatever is held or arriving. In BOOT only the PC
        // is taken (by the next-PC mux) and the boot bubble still happens.
        if (redirect_valid && state_reg != BOOT) begin
            if_valid_next = 1'b0;
            if_fault_next = 1'b0;
            state_next    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= BOOT;
            pc_reg            <= RESET_PC;
            if_valid_reg      <= 1'b0;
            if_instr_reg      <= '0;
            if_pc_reg         <= '0;
            if_compressed_reg <= 1'b0;
            if_fault_reg      <= 1'b0;
            fetch_count_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            if_valid_reg      <= if_valid_next;
            if_instr_reg      <= if_instr_next;
            if_pc_reg         <= if_pc_next;
            if_compressed_reg <= if_compressed_next;
            if_fault_reg      <= if_fault_next;
            fetch_count_reg   <= fetch_count_next;
        end
    end

    assign if_valid      = if_valid_reg;
    assign if_instr      = if_instr_reg;
    assign if_pc         = if_pc_reg;
    assign if_compressed = if_compressed_reg;
    assign if_fault      = if_fault_reg;
    assign fetch_count   = fetch_count_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a default-size instance for the main
// sequences and a 64-byte instance for the out-of-range fault.
module tb_imem_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Byte-wide IMEM image shared by both instances, little-endian windows.
    logic [7:0] mem [0:255];

    // Main instance
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr;
    logic        imem_misalign;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid, if_ready = 1'b1;
    logic [31:0] if_instr, if_pc;
    logic        if_compressed, if_fault;
    logic [31:0] fetch_count;

    // Small instance
    logic        s_rst_n = 1'b0;
    logic [31:0] s_imem_addr, s_imem_instr;
    logic        s_imem_misalign;
    logic        s_redirect_valid = 1'b0;
    logic [31:0] s_redirect_pc = '0;
    logic        s_if_valid, s_if_ready = 1'b1;
    logic [31:0] s_if_instr, s_if_pc;
    logic        s_if_compressed, s_if_fault;
    logic [31:0] s_fetch_count;

    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    assign a0 = imem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign b0 = s_imem_addr[7:0];
    assign b1 = b0 + 8'd1;
    assign b2 = b0 + 8'd2;
    assign b3 = b0 + 8'd3;

    always_comb begin
        imem_instr      = {mem[a3], mem[a2], mem[a1], mem[a0]};
        imem_misalign   = imem_addr[0];
        s_imem_instr    = {mem[b3], mem[b2], mem[b1], mem[b0]};
        s_imem_misalign = s_imem_addr[0];
    end

    imem_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .IMEM_BYTES(1024)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .imem_misalign  (imem_misalign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_compressed  (if_compressed),
        .if_fault       (if_fault),
        .fetch_count    (fetch_count)
    );

    imem_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .IMEM_BYTES(64)) u_small (
        .clk            (clk),
        .rst_n          (s_rst_n),
        .imem_addr      (s_imem_addr),
        .imem_instr     (s_imem_instr),
        .imem_misalign  (s_imem_misalign),
        .redirect_valid (s_redirect_valid),
        .redirect_pc    (s_redirect_pc),
        .if_valid       (s_if_valid),
        .if_ready       (s_if_ready),
        .if_instr       (s_if_instr),
        .if_pc          (s_if_pc),
        .if_compressed  (s_if_compressed),
        .if_fault       (s_if_fault),
        .fetch_count    (s_fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        $display("check %-24s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input int addr, input logic [31:0] v);
        for (int k = 0; k < 4; k++) mem[(addr + k) & 255] = v[8*k +: 8];
    endtask

    task automatic put16(input int addr, input logic [15:0] v);
        mem[addr & 255]       = v[7:0];
        mem[(addr + 1) & 255] = v[15:8];
    endtask

    task automatic fill_nop();
        for (int w = 0; w < 64; w++) put32(w * 4, 32'h0000_0013);
    endtask

    // Hold reset for one edge, then release; DUT is in BOOT afterwards.
    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;

        // ---- reset values and basic sequential fetch ----
        fill_nop();
        put32(0, 32'h0050_0093);
        put32(4, 32'h00A0_0113);
        if_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("boot_bubble", {31'b0, if_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'b0, if_valid}, 32'd1);
        chk("c2_instr", if_instr, 32'h0050_0093);
        chk("c2_pc", if_pc, 32'h0);
        chk("c2_comp", {31'b0, if_compressed}, 32'd0);
        tick();
        chk("c3_pc", if_pc, 32'h4);
        chk("c3_instr", if_instr, 32'h00A0_0113);
        tick();
        chk("seq_count", fetch_count, 32'd2);
        chk("seq_pc8", if_pc, 32'h8);

        // ---- mixed RVC stream ----
        fill_nop();
        put16(0, 16'h4505);
        put32(2, 32'h00A0_0113);
        put32(6, 32'h0000_0013);
        put32(10, 32'h0000_0013);
        do_reset();
        tick();
        tick();
        chk("rvc_pc0", if_pc, 32'h0);
        chk("rvc_instr0", if_instr, 32'h0000_4505);
        chk("rvc_comp0", {31'b0, if_compressed}, 32'd1);
        tick();
        chk("rvc_pc2", if_pc, 32'h2);
        chk("rvc_instr2", if_instr, 32'h00A0_0113);
        chk("rvc_comp2", {31'b0, if_compressed}, 32'd0);
        tick();
        chk("rvc_pc6", if_pc, 32'h6);

        // ---- back-pressure: hold for three edges ----
        if_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_pc", if_pc, 32'h6);
            chk("bp_instr", if_instr, 32'h0000_0013);
            chk("bp_addr", imem_addr, 32'ha);
            chk("bp_valid", {31'b0, if_valid}, 32'd1);
            chk("bp_count", fetch_count, 32'd2);
        end
        if_ready = 1'b1;
        tick();
        chk("bp_release_pc", if_pc, 32'ha);
        chk("bp_release_count", fetch_count, 32'd3);

        // ---- redirect coincident with an accepted handshake ----
        fill_nop();
        do_reset();
        tick();
        tick();
        tick();
        tick();
        chk("rd_pc8", if_pc, 32'h8);
        chk("rd_count_before", fetch_count, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rd_flush_valid", {31'b0, if_valid}, 32'd0);
        chk("rd_count_after", fetch_count, 32'd3);
        chk("rd_addr", imem_addr, 32'h40);
        tick();
        chk("rd_new_pc", if_pc, 32'h40);
        chk("rd_new_valid", {31'b0, if_valid}, 32'd1);

        // ---- misaligned redirect -> fault, held in TRAP ----
        redirect_valid = 1'b1;
        redirect_pc = 32'h11;
        tick();
        redirect_valid = 1'b0;
        chk("mis_count", fetch_count, 32'd4);
        if_ready = 1'b0;
        tick();
        chk("mis_fault", {31'b0, if_fault}, 32'd1);
        chk("mis_pc", if_pc, 32'h11);
        chk("mis_instr", if_instr, 32'h0);
        chk("mis_valid", {31'b0, if_valid}, 32'd1);
        tick();
        chk("mis_hold_fault", {31'b0, if_fault}, 32'd1);
        chk("mis_hold_addr", imem_addr, 32'h11);
        if_ready = 1'b1;
        tick();
        chk("mis_accepted_valid", {31'b0, if_valid}, 32'd0);
        chk("mis_no_count", fetch_count, 32'd4);
        tick();
        chk("trap_idle_valid", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        chk("trap_exit_fault", {31'b0, if_fault}, 32'd0);
        tick();
        chk("trap_exit_pc", if_pc, 32'h20);
        chk("trap_exit_valid", {31'b0, if_valid}, 32'd1);
        chk("trap_exit_count", fetch_count, 32'd4);
        tick();
        chk("trap_resume_count", fetch_count, 32'd5);

        // ---- out-of-range on the 64-byte instance ----
        fill_nop();
        s_if_ready = 1'b1;
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        guard = 0;
        while (!(s_if_valid && s_if_fault) && guard < 60) begin
            tick();
            guard++;
        end
        chk("oor_reached", {31'b0, s_if_fault}, 32'd1);
        chk("oor_pc", s_if_pc, 32'h40);
        chk("oor_count", s_fetch_count, 32'd16);
        s_if_ready = 1'b0;
        tick();
        chk("oor_stall_pc", s_if_pc, 32'h40);
        s_rst_n = 1'b0;
        tick();
        chk("oor_rst_valid", {31'b0, s_if_valid}, 32'd0);
        chk("oor_rst_fault", {31'b0, s_if_fault}, 32'd0);
        chk("oor_rst_pc", s_if_pc, 32'h0);
        chk("oor_rst_addr", s_imem_addr, 32'h0);
        chk("oor_rst_count", s_fetch_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
